// File: rtl/trigger_sequencer_if.sv
// Bundled configuration, control and status signals of the trigger sequencer.
// The master side drives configuration/control; the slave side is the sequencer.
interface trigger_sequencer_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [2:0]       cfg_event;
    logic [CNT_W-1:0] cfg_count;
    logic [1:0]       num_stages;
    logic [CNT_W-1:0] post_count;
    logic             arm;
    logic             abort;
    logic             hit;
    logic [2:0]       trig_event;
    logic [1:0]       stage;
    logic             busy;
    logic             triggered;
    logic             capture;
    logic             done;
    logic             timeout_flag;

    modport master (
        output cfg_we, cfg_addr, cfg_event, cfg_count, num_stages, post_count, arm, abort, hit,
        input  trig_event, stage, busy, triggered, capture, done, timeout_flag
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_event, cfg_count, num_stages, post_count, arm, abort, hit,
        output trig_event, stage, busy, triggered, capture, done, timeout_flag
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Four-stage trigger sequencer with hit counting and post-trigger capture window.
// Define TRIG_TIMEOUT_EN to enable the per-stage idle timeout back to stage 0.
module trigger_sequencer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clock,
    input  logic              reset,
    trigger_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       stage_q, stage_d;
    logic [1:0]       num_stages_q, num_stages_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0] post_len_q, post_len_d;
    logic [2:0]       evt_tbl_q [4];
    logic [2:0]       evt_tbl_d [4];
    logic [CNT_W-1:0] cnt_tbl_q [4];
    logic [CNT_W-1:0] cnt_tbl_d [4];
    logic [2:0]       trig_event_q, trig_event_d;
    logic             triggered_q, triggered_d;
    logic             timeout_q, timeout_d;

    logic [2:0]       cur_code;
    logic [2:0]       nxt_code;
    logic             pass_thru;
    logic [CNT_W-1:0] cur_need;
    logic             complete;
    logic             timed_out;

    always_comb begin
        cur_code  = evt_tbl_q[stage_q];
        pass_thru = (cur_code == 3'd0) || (cur_code > 3'd5);
        cur_need  = (cnt_tbl_q[stage_q] == '0) ? CNT_W'(1) : cnt_tbl_q[stage_q];
        // Completion at need-1 means the counter never wraps.
        complete  = pass_thru || (bus.hit && (hit_cnt_q == cur_need - CNT_W'(1)));
    end

`ifdef TRIG_TIMEOUT_EN
    localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [IdleW-1:0] idle_q, idle_d;

    always_comb begin
        timed_out = 1'b0;
        idle_d    = '0;
        if (state_q == StArmed && stage_q != 2'd0 && !bus.abort && !bus.hit && !complete) begin
            if (idle_q == IdleW'(TIMEOUT - 1)) begin
                timed_out = 1'b1;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        num_stages_d = num_stages_q;
        hit_cnt_d    = hit_cnt_q;
        post_cnt_d   = post_cnt_q;
        post_len_d   = post_len_q;
        evt_tbl_d    = evt_tbl_q;
        cnt_tbl_d    = cnt_tbl_q;
        triggered_d  = 1'b0;
        timeout_d    = 1'b0;
        if (bus.abort) begin
            state_d    = StIdle;
            stage_d    = 2'd0;
            hit_cnt_d  = '0;
            post_cnt_d = '0;
        end else begin
            if (bus.cfg_we && (state_q == StIdle || state_q == StDone)) begin
                evt_tbl_d[bus.cfg_addr] = bus.cfg_event;
                cnt_tbl_d[bus.cfg_addr] = bus.cfg_count;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.arm) begin
                        state_d      = StArmed;
                        stage_d      = 2'd0;
                        hit_cnt_d    = '0;
                        num_stages_d = bus.num_stages;
                        post_len_d   = bus.post_count;
                    end
                end
                StArmed: begin
                    if (complete) begin
                        hit_cnt_d = '0;
                        if (stage_q != num_stages_q) begin
                            stage_d = stage_q + 2'd1;
                        end else begin
                            triggered_d = 1'b1;
                            if (post_len_q == '0) begin
                                state_d = StDone;
                            end else begin
                                state_d    = StPost;
                                post_cnt_d = post_len_q - CNT_W'(1);
                            end
                        end
                    end else if (timed_out) begin
                        stage_d   = 2'd0;
                        hit_cnt_d = '0;
                        timeout_d = 1'b1;
                    end else if (bus.hit) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                end
                StPost: begin
                    if (post_cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        post_cnt_d = post_cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        // Detector code follows the stage that will be active next cycle.
        nxt_code     = evt_tbl_q[stage_d];
        trig_event_d = 3'd0;
        if (state_d == StArmed && nxt_code != 3'd0 && nxt_code <= 3'd5) begin
            trig_event_d = nxt_code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            stage_q      <= 2'd0;
            num_stages_q <= 2'd0;
            hit_cnt_q    <= '0;
            post_cnt_q   <= '0;
            post_len_q   <= '0;
            trig_event_q <= 3'd0;
            triggered_q  <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                evt_tbl_q[i] <= 3'd0;
                cnt_tbl_q[i] <= CNT_W'(1);
            end
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            num_stages_q <= num_stages_d;
            hit_cnt_q    <= hit_cnt_d;
            post_cnt_q   <= post_cnt_d;
            post_len_q   <= post_len_d;
            trig_event_q <= trig_event_d;
            triggered_q  <= triggered_d;
            timeout_q    <= timeout_d;
            evt_tbl_q    <= evt_tbl_d;
            cnt_tbl_q    <= cnt_tbl_d;
        end
    end

    assign bus.trig_event   = trig_event_q;
    assign bus.stage        = stage_q;
    assign bus.busy         = (state_q == StArmed) || (state_q == StPost);
    assign bus.triggered    = triggered_q;
    assign bus.capture      = (state_q == StPost);
    assign bus.done         = (state_q == StDone);
    assign bus.timeout_flag = timeout_q;
endmodule
